// File: rtl/tm_seq_pkg.sv
// Shared phase encoding and default parameters for the Turing machine input sequencer.
package tm_seq_pkg;

  localparam int unsigned DefaultDw             = 4;
  localparam int unsigned DefaultAw             = 6;
  localparam int unsigned DefaultDebounceCycles = 16;
  localparam int unsigned DefaultMinHigh        = 2;
  localparam int unsigned DefaultStepPeriod     = 64;

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } phase_e;

  localparam logic [1:0] PhaseLoad   = 2'd0;
  localparam logic [1:0] PhaseRun    = 2'd1;
  localparam logic [1:0] PhaseHalted = 2'd2;

  function automatic logic [1:0] phase_code(phase_e ph);
    case (ph)
      StRun:    return PhaseRun;
      StHalted: return PhaseHalted;
      default:  return PhaseLoad;
    endcase
  endfunction

endpackage

// File: rtl/tm_debounce.sv
// Two-flop synchronizer followed by a stability counter; reports the accepted level and
// a one-cycle pulse when that level rises.
module tm_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/tm_input_sequencer.sv
// Front end for the Turing machine core: debounced buttons, Next/Done shaping and phase
// tracking. Optional periodic stepping in RUN is enabled by defining TM_AUTOSTEP_EN.
module tm_input_sequencer import tm_seq_pkg::*; #(
  parameter int unsigned DW              = DefaultDw,
  parameter int unsigned AW              = DefaultAw,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned MIN_HIGH        = DefaultMinHigh,
  parameter int unsigned STEP_PERIOD     = DefaultStepPeriod
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          btn_next_raw,
  input  logic          btn_done_raw,
  input  logic [DW-1:0] sw_data,
  input  logic          compute_done,
  output logic          next,
  output logic          done,
  output logic [DW-1:0] input_data,
  output logic [AW-1:0] word_count,
  output logic [1:0]    phase,
  output logic          overflow
);

  localparam int unsigned HW = $clog2(MIN_HIGH + 1);

  logic next_lvl, next_rise, done_rise, done_lvl_unused;
  logic step_trig, start;

  phase_e        phase_q, phase_d;
  logic          next_q, next_d;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic          done_q, done_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] wc_q, wc_d;
  logic          ovf_q, ovf_d;
  logic          halt_pend_q, halt_pend_d;

  tm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_next (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (btn_next_raw),
    .level  (next_lvl),
    .rise   (next_rise)
  );

  tm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_done (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (btn_done_raw),
    .level  (done_lvl_unused),
    .rise   (done_rise)
  );

`ifdef TM_AUTOSTEP_EN
  localparam int unsigned SW = $clog2(STEP_PERIOD);

  logic [SW-1:0] step_cnt_q, step_cnt_d;

  // Held at zero outside RUN so each RUN entry restarts a full period.
  always_comb begin
    step_cnt_d = '0;
    step_trig  = 1'b0;
    if (phase_q == StRun) begin
      if (step_cnt_q == SW'(STEP_PERIOD - 1)) begin
        step_trig = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end
`else
  localparam int unsigned unused_step_period = STEP_PERIOD;
  assign step_trig = 1'b0;
`endif

  always_comb begin
    phase_d     = phase_q;
    next_d      = next_q;
    hi_cnt_d    = hi_cnt_q;
    done_d      = 1'b0;
    data_d      = data_q;
    wc_d        = wc_q;
    ovf_d       = ovf_q;
    halt_pend_d = halt_pend_q;
    start       = 1'b0;

    // Stretch to MIN_HIGH, then follow the debounced button level.
    if (next_q) begin
      if (hi_cnt_q < HW'(MIN_HIGH)) begin
        hi_cnt_d = hi_cnt_q + HW'(1);
      end else if (!next_lvl) begin
        next_d = 1'b0;
      end
    end

    case (phase_q)
      StLoad: begin
        if (next_rise) begin
          if (!next_q) begin
            if (wc_q == {AW{1'b1}}) begin
              ovf_d = 1'b1;
            end else begin
              start  = 1'b1;
              data_d = sw_data;
              wc_d   = wc_q + AW'(1);
            end
          end
        end else if (done_rise && !next_q && (wc_q != '0)) begin
          done_d  = 1'b1;
          phase_d = StRun;
        end
      end
      StRun: begin
        // A compute_done seen while stepping is remembered until next has dropped.
        if ((compute_done || halt_pend_q) && !next_q) begin
          phase_d     = StHalted;
          halt_pend_d = 1'b0;
        end else begin
          if (compute_done) halt_pend_d = 1'b1;
          if ((next_rise || step_trig) && !next_q) start = 1'b1;
        end
      end
      StHalted: begin
        next_d = 1'b0;
      end
      default: begin
        phase_d = StLoad;
      end
    endcase

    if (start) begin
      next_d   = 1'b1;
      hi_cnt_d = HW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= StLoad;
      next_q      <= 1'b0;
      hi_cnt_q    <= '0;
      done_q      <= 1'b0;
      data_q      <= '0;
      wc_q        <= '0;
      ovf_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      next_q      <= next_d;
      hi_cnt_q    <= hi_cnt_d;
      done_q      <= done_d;
      data_q      <= data_d;
      wc_q        <= wc_d;
      ovf_q       <= ovf_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign next       = next_q;
  assign done       = done_q;
  assign input_data = data_q;
  assign word_count = wc_q;
  assign phase      = phase_code(phase_q);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Directed scenarios plus randomized button traffic checked against a behavioural model.
module tb_tm_input_sequencer;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int DB = 16;
  localparam int MH = 2;
  localparam int WMAX = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn_next_raw = 1'b0;
  logic          btn_done_raw = 1'b0;
  logic [DW-1:0] sw_data = '0;
  logic          compute_done = 1'b0;
  logic          next, done, overflow;
  logic [DW-1:0] input_data;
  logic [AW-1:0] word_count;
  logic [1:0]    phase;

  always #5 clock = ~clock;

  tm_input_sequencer #(
    .DW(DW), .AW(AW), .DEBOUNCE_CYCLES(DB), .MIN_HIGH(MH), .STEP_PERIOD(64)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_next_raw(btn_next_raw),
    .btn_done_raw(btn_done_raw),
    .sw_data     (sw_data),
    .compute_done(compute_done),
    .next        (next),
    .done        (done),
    .input_data  (input_data),
    .word_count  (word_count),
    .phase       (phase),
    .overflow    (overflow)
  );

  wire [10:0] dvec = {next, done, input_data, word_count, phase, overflow};

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model: raw-sample histories and the spec's phase/next rules.
  bit        hn[0:DB+1];
  bit        hd[0:DB+1];
  bit        m_ln, m_ld, m_rn, m_rd;
  bit        m_next, m_done, m_ovf, m_pend;
  int        m_phase, m_age, m_wc;
  logic [3:0] m_data;

  function automatic logic [10:0] mvec();
    return {m_next, m_done, m_data, 2'(m_wc), 2'(m_phase), m_ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DB + 2; i++) begin
      hn[i] = 1'b0;
      hd[i] = 1'b0;
    end
    m_ln = 0; m_ld = 0; m_rn = 0; m_rd = 0;
    m_next = 0; m_done = 0; m_ovf = 0; m_pend = 0;
    m_phase = 0; m_age = 0; m_wc = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit nr, dr, nl, was_next, start, all_diff;
    nr = m_rn; dr = m_rd; nl = m_ln;
    was_next = m_next;
    start = 0;
    m_done = 0;
    if (m_next) begin
      if (m_age >= MH && !nl) m_next = 0;
      else m_age++;
    end
    case (m_phase)
      0: begin
        if (nr) begin
          if (!was_next) begin
            if (m_wc == WMAX) m_ovf = 1;
            else begin m_wc++; m_data = sw_data; start = 1; end
          end
        end else if (dr && !was_next && m_wc > 0) begin
          m_done = 1; m_phase = 1;
        end
      end
      1: begin
        if ((compute_done || m_pend) && !was_next) begin
          m_phase = 2; m_pend = 0;
        end else begin
          if (compute_done) m_pend = 1;
          if (nr && !was_next) start = 1;
        end
      end
      default: ;
    endcase
    if (start) begin m_next = 1; m_age = 1; end
    // Level flips when the last DB synchronized samples (raw delayed 2) all disagree.
    for (int i = DB + 1; i > 0; i--) begin hn[i] = hn[i-1]; hd[i] = hd[i-1]; end
    hn[0] = btn_next_raw;
    hd[0] = btn_done_raw;
    all_diff = 1;
    for (int k = 0; k < DB; k++) if (hn[2+k] == m_ln) all_diff = 0;
    m_rn = all_diff && !m_ln;
    if (all_diff) m_ln = !m_ln;
    all_diff = 1;
    for (int k = 0; k < DB; k++) if (hd[2+k] == m_ld) all_diff = 0;
    m_rd = all_diff && !m_ld;
    if (all_diff) m_ld = !m_ld;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_next_raw = 1'b0;
    btn_done_raw = 1'b0;
    compute_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Press statistics gathered by press(); each test judges them itself.
  int s_rises, s_high, s_done, s_rise_at, s_fall_at, s_halt_at, s_done_at, s_data_bad;

  task automatic press(input bit use_done, input int hi, input int lo,
                       input logic [3:0] w, input bit cd_pulse);
    bit prev;
    s_rises = 0; s_high = 0; s_done = 0; s_data_bad = 0;
    s_rise_at = -1; s_fall_at = -1; s_halt_at = -1; s_done_at = -1;
    prev = next;
    for (int t = 1; t <= hi + lo; t++) begin
      if (use_done) btn_done_raw = (t <= hi);
      else btn_next_raw = (t <= hi);
      tick();
      compute_done = 1'b0;
      if (next && !prev) begin
        s_rises++;
        if (s_rise_at < 0) s_rise_at = t;
        if (cd_pulse) compute_done = 1'b1;
      end
      if (!next && prev && s_fall_at < 0) s_fall_at = t;
      if (phase == 2'd2 && s_halt_at < 0) s_halt_at = t;
      if (next) begin
        s_high++;
        if (input_data !== w) s_data_bad++;
      end
      if (done) begin
        s_done++;
        if (s_done_at < 0) s_done_at = t;
      end
      prev = next;
    end
    btn_next_raw = 1'b0;
    btn_done_raw = 1'b0;
    compute_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (dvec !== 11'b0) $display("FAIL reset_state: got %h want 000", dvec);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (dvec !== mvec() || dvec !== 11'b0)
      $display("FAIL reset_idle: got %h want %h", dvec, mvec());
    else n_pass++;
  endtask

  task automatic test_done_empty();
    press(1'b1, 30, 30, 4'h0, 1'b0);
    n_chk++;
    if (s_done !== 0 || phase !== 2'd0)
      $display("FAIL done_empty: done_cycles=%0d phase=%0d want 0/0", s_done, phase);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int bounce_rises;
    bounce_rises = 0;
    sw_data = 4'h3;
    for (int i = 0; i < 40; i++) begin
      btn_next_raw = ((i / 3) % 2 == 0);
      tick();
      if (next) bounce_rises++;
    end
    press(1'b0, 30, 30, 4'h3, 1'b0);
    n_chk++;
    if (bounce_rises + s_rises !== 1)
      $display("FAIL bounce_count: rises=%0d want 1", bounce_rises + s_rises);
    else n_pass++;
    n_chk++;
    if (s_rise_at !== DB + 3) $display("FAIL bounce_latency: got %0d want %0d", s_rise_at, DB + 3);
    else n_pass++;
    n_chk++;
    if (s_data_bad !== 0 || word_count !== 2'd1)
      $display("FAIL bounce_data: bad=%0d wc=%0d want 0/1", s_data_bad, word_count);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [3:0] words [3];
    words[0] = 4'h3; words[1] = 4'hA; words[2] = 4'h5;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sw_data = words[i];
      press(1'b0, 30, 30, words[i], 1'b0);
      n_chk++;
      if (s_rises !== 1 || s_high !== 30 || s_data_bad !== 0)
        $display("FAIL load_word%0d: rises=%0d high=%0d bad=%0d want 1/30/0",
                 i, s_rises, s_high, s_data_bad);
      else n_pass++;
    end
    n_chk++;
    if (word_count !== 2'd3 || input_data !== 4'h5 || dvec !== mvec())
      $display("FAIL load_final: wc=%0d data=%h vec=%h want 3/5/%h",
               word_count, input_data, dvec, mvec());
    else n_pass++;
  endtask

  task automatic test_overflow();
    sw_data = 4'hF;
    press(1'b0, 30, 30, 4'h5, 1'b0);
    n_chk++;
    if (s_rises !== 0 || word_count !== 2'd3 || overflow !== 1'b1 || input_data !== 4'h5)
      $display("FAIL overflow: rises=%0d wc=%0d ovf=%0d data=%h want 0/3/1/5",
               s_rises, word_count, overflow, input_data);
    else n_pass++;
  endtask

  task automatic test_done_run();
    press(1'b1, 30, 30, 4'h5, 1'b0);
    n_chk++;
    if (s_done !== 1 || s_done_at !== DB + 3)
      $display("FAIL done_pulse: cycles=%0d at=%0d want 1/%0d", s_done, s_done_at, DB + 3);
    else n_pass++;
    n_chk++;
    if (phase !== 2'd1 || dvec !== mvec())
      $display("FAIL done_phase: phase=%0d vec=%h want 1/%h", phase, dvec, mvec());
    else n_pass++;
  endtask

  task automatic test_halt();
    press(1'b0, 30, 30, 4'h5, 1'b1);
    n_chk++;
    if (s_rises !== 1 || s_fall_at < 0 || s_halt_at !== s_fall_at + 1)
      $display("FAIL halt_defer: rises=%0d fall=%0d halt=%0d want 1/f/f+1",
               s_rises, s_fall_at, s_halt_at);
    else n_pass++;
    press(1'b0, 30, 30, 4'h5, 1'b0);
    n_chk++;
    if (s_rises !== 0 || phase !== 2'd2 || s_done !== 0)
      $display("FAIL halt_ignore: rises=%0d phase=%0d done=%0d want 0/2/0",
               s_rises, phase, s_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sw_data = 4'h6;
    btn_next_raw = 1'b1;
    repeat (20) tick();
    n_chk++;
    if (next !== 1'b1 || input_data !== 4'h6)
      $display("FAIL mid_pre: next=%0d data=%h want 1/6", next, input_data);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (dvec !== 11'b0) $display("FAIL mid_reset_async: got %h want 000", dvec);
    else n_pass++;
    @(negedge clock);
    btn_next_raw = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (phase !== 2'd0 || dvec !== mvec())
      $display("FAIL mid_release: phase=%0d vec=%h want 0/%h", phase, dvec, mvec());
    else n_pass++;
  endtask

  task automatic test_random();
    int left_n, left_d;
    left_n = 0; left_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 1000 == 0) begin
        do_reset();
        left_n = 0; left_d = 0;
      end
      if (left_n == 0) begin
        btn_next_raw = ~btn_next_raw;
        left_n = $urandom_range(1, 45);
      end else left_n--;
      if (left_d == 0) begin
        btn_done_raw = ~btn_done_raw;
        left_d = $urandom_range(1, 60);
      end else left_d--;
      compute_done = ($urandom_range(0, 19) == 0);
      sw_data = 4'($urandom);
      tick();
      n_chk++;
      if (dvec !== mvec()) $display("FAIL random c=%0d: got %h want %h", cyc, dvec, mvec());
      else n_pass++;
    end
    btn_next_raw = 1'b0;
    btn_done_raw = 1'b0;
    compute_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_done_empty();
    test_bounce();
    test_load();
    test_overflow();
    test_done_run();
    test_halt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
